// File: rtl/onewire_master_mc.sv
// ============================================================================
// Module   : onewire_master_mc
// Brief    : Multi-channel 1-Wire bus master with one shared timing engine.
//            Define ONEWIRE_CRC8_EN to build the Dallas CRC8 on read bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onewire_master_mc #(
  parameter int CLK_HZ = 10_000_000,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [7:0]        cmd_data,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_presence,
  output logic              rsp_err,
  output logic [NUM_CH-1:0] dq_oe,
  input  logic [NUM_CH-1:0] dq_in,
  output logic [7:0]        crc_out
);

  localparam int c_div   = CLK_HZ / 1_000_000;
  localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;

  localparam logic [1:0] c_op_rst = 2'b00;
  localparam logic [1:0] c_op_wr  = 2'b01;
  localparam logic [1:0] c_op_rd  = 2'b10;
  localparam logic [1:0] c_op_rsv = 2'b11;

  // Phase end points are the last microsecond index of each phase.
  localparam logic [8:0] c_rst_end = 9'd479;
  localparam logic [8:0] c_pres_at = 9'd69;
  localparam logic [8:0] c_samp_at = 9'd8;
  localparam logic [8:0] c_rec_end = 9'd1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_LOW  = 3'd1,
    RST_WAIT = 3'd2,
    SLOT_LOW = 3'd3,
    SLOT_REL = 3'd4,
    SLOT_REC = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_div_w-1:0] r_div;
  logic [8:0]         r_us;
  logic [1:0]         r_op;
  logic [CH_W-1:0]    r_ch;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit;
  logic               r_pres;

  logic               w_tick;
  logic               w_accept;
  logic               w_bad;
  logic               w_line_low;
  logic               w_dq_bit;
  logic               w_samp;
  logic               w_short;
  logic [8:0]         w_low_end;
  logic [8:0]         w_rel_end;
  logic [NUM_CH-1:0]  w_sel;

  assign w_tick    = (r_div == c_div_w'(c_div - 1));
  assign w_bad     = ({1'b0, cmd_ch} >= (CH_W+1)'(NUM_CH)) || (cmd_op == c_op_rsv);
  // Reads and write-1 slots use the short 6 us low pulse.
  assign w_short   = (r_op != c_op_wr) || r_shift[0];
  assign w_low_end = w_short ? 9'd5  : 9'd59;
  assign w_rel_end = w_short ? 9'd63 : 9'd9;
  assign w_samp    = (r_state == SLOT_REL) && (r_op == c_op_rd) && w_tick && (r_us == c_samp_at);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_sel[i] = (r_ch == CH_W'(i));
    end
  endgenerate

  assign dq_oe    = w_line_low ? w_sel : '0;
  assign w_dq_bit = |(dq_in & w_sel);

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_line_low   = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        w_accept  = cmd_valid;
        if (cmd_valid) begin
          if (w_bad)                  w_state_next = DONE;
          else if (cmd_op == c_op_rst) w_state_next = RST_LOW;
          else                        w_state_next = SLOT_LOW;
        end
      end
      RST_LOW: begin
        w_line_low = 1'b1;
        if (w_tick && r_us == c_rst_end) w_state_next = RST_WAIT;
      end
      RST_WAIT: begin
        if (w_tick && r_us == c_rst_end) w_state_next = DONE;
      end
      SLOT_LOW: begin
        w_line_low = 1'b1;
        if (w_tick && r_us == w_low_end) w_state_next = SLOT_REL;
      end
      SLOT_REL: begin
        if (w_tick && r_us == w_rel_end) w_state_next = SLOT_REC;
      end
      SLOT_REC: begin
        if (w_tick && r_us == c_rec_end) w_state_next = (r_bit == 3'd7) ? DONE : SLOT_LOW;
      end
      DONE: begin
        rsp_valid    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_div        <= '0;
      r_us         <= '0;
      r_op         <= '0;
      r_ch         <= '0;
      r_shift      <= '0;
      r_bit        <= '0;
      r_pres       <= 1'b0;
      rsp_data     <= '0;
      rsp_presence <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // The divider restarts on accept so every phase is tick-aligned.
      if (w_accept || w_tick) r_div <= '0;
      else                    r_div <= r_div + 1'b1;

      if (w_state_next != r_state) r_us <= '0;
      else if (w_tick)             r_us <= r_us + 9'd1;

      if (w_accept) begin
        r_op    <= cmd_op;
        r_ch    <= cmd_ch;
        r_shift <= cmd_data;
        r_bit   <= '0;
        r_pres  <= 1'b0;
      end

      if (r_state == RST_WAIT && w_tick && r_us == c_pres_at) r_pres <= ~w_dq_bit;

      if (w_samp) r_shift <= {w_dq_bit, r_shift[7:1]};
      else if (r_state == SLOT_REL && r_op == c_op_wr && w_state_next == SLOT_REC)
        r_shift <= {1'b0, r_shift[7:1]};

      if (r_state == SLOT_REC && w_state_next != SLOT_REC) r_bit <= r_bit + 3'd1;

      if (w_state_next == DONE) begin
        rsp_err      <= (r_state == IDLE);
        rsp_presence <= (r_state == RST_WAIT) && r_pres;
        rsp_data     <= (r_state == SLOT_REC && r_op == c_op_rd) ? r_shift : 8'h00;
      end
    end
  end

`ifdef ONEWIRE_CRC8_EN
  logic [7:0] r_crc;

  // Reflected Dallas CRC8, one step per received bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (w_accept && cmd_op == c_op_rst) begin
      r_crc <= '0;
    end else if (w_samp) begin
      r_crc <= {1'b0, r_crc[7:1]} ^ ((r_crc[0] ^ w_dq_bit) ? 8'h8C : 8'h00);
    end
  end

  assign crc_out = r_crc;
`else
  assign crc_out = 8'h00;
`endif

endmodule

`default_nettype wire
